// File: rtl/dmem_ahb_bridge.sv
// Single-outstanding bridge from the core dmem port to an AHB-Lite master.
// Each access becomes one SINGLE transfer; misaligned accesses are rejected locally.
module dmem_ahb_bridge #(
  parameter int XLEN   = 32,
  parameter int WCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_req,
  input  logic              dmem_cmd,
  input  logic [1:0]        dmem_width,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_resp,
  output logic [XLEN-1:0]   haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [XLEN-1:0]   hwdata,
  input  logic [XLEN-1:0]   hrdata,
  input  logic              hready,
  input  logic              hresp,
  output logic              bus_err,
  output logic              misalign,
  output logic [XLEN-1:0]   err_addr,
  output logic [WCNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [XLEN-1:0]   hwdata_q, hwdata_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              dmem_resp_q, dmem_resp_d;
  logic [XLEN-1:0]   dmem_rdata_q, dmem_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   err_addr_q, err_addr_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [1:0] width_n;
  logic       aligned;

  // Width 3 is handled exactly like a word access, including the bus size.
  assign width_n = (dmem_width == 2'd3) ? 2'd2 : dmem_width;
  assign aligned = (width_n == 2'd0) ||
                   ((width_n == 2'd1) && !dmem_addr[0]) ||
                   (dmem_addr[1:0] == 2'b00);

  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    htrans_d     = htrans_q;
    hwdata_d     = hwdata_q;
    wdata_d      = wdata_q;
    dmem_rdata_d = dmem_rdata_q;
    err_addr_d   = err_addr_q;
    wait_cnt_d   = wait_cnt_q;
    dmem_resp_d  = 1'b0;
    bus_err_d    = 1'b0;
    misalign_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dmem_req) begin
          if (aligned) begin
            state_d  = S_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = dmem_addr;
            hwrite_d = dmem_cmd;
            hsize_d  = {1'b0, width_n};
            wdata_d  = dmem_wdata;
          end else begin
            state_d      = S_RESP;
            dmem_resp_d  = 1'b1;
            misalign_d   = 1'b1;
            err_addr_d   = dmem_addr;
            dmem_rdata_d = '0;
          end
        end
      end

      S_ADDR: begin
        if (hready) begin
          state_d  = S_DATA;
          htrans_d = HTRANS_IDLE;
          unique case (hsize_q[1:0])
            2'd0:    hwdata_d = {4{wdata_q[7:0]}};
            2'd1:    hwdata_d = {2{wdata_q[15:0]}};
            default: hwdata_d = wdata_q;
          endcase
        end
      end

      S_DATA: begin
        if (!hready) begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          state_d     = S_RESP;
          dmem_resp_d = 1'b1;
          if (hresp) begin
            dmem_rdata_d = '0;
            bus_err_d    = 1'b1;
            err_addr_d   = haddr_q;
          end else begin
            dmem_rdata_d = hwrite_q ? '0 : hrdata;
          end
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      htrans_q     <= HTRANS_IDLE;
      hwdata_q     <= '0;
      wdata_q      <= '0;
      dmem_resp_q  <= 1'b0;
      dmem_rdata_q <= '0;
      bus_err_q    <= 1'b0;
      misalign_q   <= 1'b0;
      err_addr_q   <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      htrans_q     <= htrans_d;
      hwdata_q     <= hwdata_d;
      wdata_q      <= wdata_d;
      dmem_resp_q  <= dmem_resp_d;
      dmem_rdata_q <= dmem_rdata_d;
      bus_err_q    <= bus_err_d;
      misalign_q   <= misalign_d;
      err_addr_q   <= err_addr_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign haddr      = haddr_q;
  assign hwrite     = hwrite_q;
  assign hsize      = hsize_q;
  assign htrans     = htrans_q;
  assign hburst     = 3'b000;
  assign hwdata     = hwdata_q;
  assign dmem_resp  = dmem_resp_q;
  assign dmem_rdata = dmem_rdata_q;
  assign bus_err    = bus_err_q;
  assign misalign   = misalign_q;
  assign err_addr   = err_addr_q;
  assign wait_cnt   = wait_cnt_q;

endmodule

// File: tb/tb_dmem_ahb_bridge.sv
// Bench for dmem_ahb_bridge: a vector table of single accesses against a reactive
// AHB slave, plus back-to-back and asynchronous-reset sequences.
module tb_dmem_ahb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] hrdata;
  logic        hready, hresp;

  logic [31:0] dmem_rdata, haddr, hwdata, err_addr;
  logic        dmem_resp, hwrite, bus_err, misalign;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [15:0] wait_cnt;

  logic [31:0] dmem_rdata_s, haddr_s, hwdata_s, err_addr_s;
  logic        dmem_resp_s, hwrite_s, bus_err_s, misalign_s;
  logic [1:0]  htrans_s;
  logic [2:0]  hsize_s, hburst_s;
  logic [1:0]  wait_cnt_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_ahb_bridge #(.XLEN(32), .WCNT_W(16)) dut (
    .clk(clk), .rst(rst), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .bus_err(bus_err),
    .misalign(misalign), .err_addr(err_addr), .wait_cnt(wait_cnt)
  );

  dmem_ahb_bridge #(.XLEN(32), .WCNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata_s), .dmem_resp(dmem_resp_s), .haddr(haddr_s), .htrans(htrans_s),
    .hwrite(hwrite_s), .hsize(hsize_s), .hburst(hburst_s), .hwdata(hwdata_s),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .bus_err(bus_err_s),
    .misalign(misalign_s), .err_addr(err_addr_s), .wait_cnt(wait_cnt_s)
  );

  typedef struct {
    string       name;
    logic        cmd;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_bus;
    int          aw;
    int          dw;
    bit          err;
    int          exp_lat;
    bit          exp_ns;
    logic [31:0] exp_rdata;
    logic [31:0] exp_hwdata;
    logic [2:0]  exp_hsize;
    bit          exp_mis;
    bit          exp_berr;
    logic [31:0] exp_eaddr;
    logic [15:0] exp_wait;
    logic [1:0]  exp_wait_s;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic run_vec(input vec_t v);
    int lat = -1, first_ns = -1, ns_cnt = 0, aw = v.aw, dw = v.dw;
    bit in_data = 0, hw_bad = 0;
    logic [31:0] r_rdata = '0, r_eaddr = '0, r_haddr = '0, r_rdata_s = '0;
    logic        r_mis = 0, r_berr = 0, r_hwrite = 0, r_resp_s = 0;
    logic [2:0]  r_hsize = '0;
    @(negedge clk);
    dmem_req = 1'b1; dmem_cmd = v.cmd; dmem_width = v.width;
    dmem_addr = v.addr; dmem_wdata = v.wdata; hrdata = v.rdata_bus;
    hready = 1'b1; hresp = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(negedge clk);
      if (dmem_resp) begin
        lat = cyc; r_rdata = dmem_rdata; r_eaddr = err_addr;
        r_mis = misalign; r_berr = bus_err;
        r_resp_s = dmem_resp_s; r_rdata_s = dmem_rdata_s;
        dmem_req = 1'b0; hready = 1'b1; hresp = 1'b0;
      end else if (in_data) begin
        if (htrans == 2'b10) ns_cnt++;
        if (v.cmd && hwdata !== v.exp_hwdata) hw_bad = 1;
        if (dw > 0) begin
          hready = 1'b0; hresp = v.err && (dw == 1); dw--;
        end else begin
          hready = 1'b1; hresp = v.err; in_data = 0;
        end
      end else if (htrans == 2'b10) begin
        ns_cnt++;
        if (first_ns < 0) begin
          first_ns = cyc; r_haddr = haddr; r_hsize = hsize; r_hwrite = hwrite;
        end
        if (aw > 0) begin hready = 1'b0; aw--; end
        else begin hready = 1'b1; in_data = 1; end
      end else begin
        hready = 1'b1;
      end
    end
    chk({v.name, " latency"}, lat, v.exp_lat);
    chk({v.name, " rdata"}, r_rdata, v.exp_rdata);
    chk({v.name, " misalign"}, {31'd0, r_mis}, {31'd0, v.exp_mis});
    chk({v.name, " bus_err"}, {31'd0, r_berr}, {31'd0, v.exp_berr});
    chk({v.name, " err_addr"}, r_eaddr, v.exp_eaddr);
    chk({v.name, " small resp/rdata"}, {31'd0, r_resp_s} ^ r_rdata_s, 32'd1 ^ v.exp_rdata);
    if (v.exp_ns) begin
      chk({v.name, " first nonseq"}, first_ns, 1);
      chk({v.name, " nonseq cycles"}, ns_cnt, v.aw + 1);
      chk({v.name, " haddr"}, r_haddr, v.addr);
      chk({v.name, " hsize"}, {29'd0, r_hsize}, {29'd0, v.exp_hsize});
      chk({v.name, " hwrite"}, {31'd0, r_hwrite}, {31'd0, v.cmd});
      if (v.cmd) chk({v.name, " hwdata held"}, {31'd0, hw_bad}, 32'd0);
    end else begin
      chk({v.name, " no nonseq"}, ns_cnt, 0);
    end
    @(negedge clk);
    chk({v.name, " pulse end"}, {29'd0, dmem_resp, bus_err, misalign}, 32'd0);
    chk({v.name, " wait_cnt"}, {16'd0, wait_cnt}, {16'd0, v.exp_wait});
    chk({v.name, " wait_cnt w2"}, {30'd0, wait_cnt_s}, {30'd0, v.exp_wait_s});
    chk({v.name, " hburst"}, {29'd0, hburst}, 32'd0);
  endtask

  initial begin
    int ns1, ns2, ns_n, rsp_n, lat_ok;
    logic [31:0] rd2;
    //          name      cmd wd addr          wdata         bus rdata     aw dw err lat ns exp_rdata     exp_hwdata    hsz  mis be eaddr         wait s
    vecs[0] = '{"wrd_rd", 0, 2, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 3, 1, 32'hDEAD_BEEF, 32'h0,        3'd2, 0, 0, 32'h0,        16'd0, 2'd0};
    vecs[1] = '{"byt_wr", 1, 0, 32'h0000_2003, 32'h0000_00A5, 32'h1111_1111, 0, 3, 0, 6, 1, 32'h0,        32'hA5A5_A5A5, 3'd0, 0, 0, 32'h0,        16'd3, 2'd3};
    vecs[2] = '{"mis_hf", 0, 1, 32'h0000_3001, 32'h0,        32'h2222_2222, 0, 0, 0, 1, 0, 32'h0,        32'h0,        3'd1, 1, 0, 32'h0000_3001, 16'd3, 2'd3};
    vecs[3] = '{"err_wr", 1, 2, 32'h0000_4000, 32'h1234_5678, 32'h3333_3333, 0, 1, 1, 4, 1, 32'h0,        32'h1234_5678, 3'd2, 0, 1, 32'h0000_4000, 16'd4, 2'd3};
    vecs[4] = '{"hf_wr",  1, 1, 32'h0000_5002, 32'h0000_BEEF, 32'h4444_4444, 1, 0, 0, 4, 1, 32'h0,        32'hBEEF_BEEF, 3'd1, 0, 0, 32'h0000_4000, 16'd4, 2'd3};
    vecs[5] = '{"hf_rd",  0, 1, 32'h0000_6002, 32'h0,        32'hCAFE_F00D, 0, 2, 0, 5, 1, 32'hCAFE_F00D, 32'h0,        3'd1, 0, 0, 32'h0000_4000, 16'd6, 2'd3};
    vecs[6] = '{"mis_wd", 0, 2, 32'h0000_7002, 32'h0,        32'h5555_5555, 0, 0, 0, 1, 0, 32'h0,        32'h0,        3'd2, 1, 0, 32'h0000_7002, 16'd6, 2'd3};
    vecs[7] = '{"byt_rd", 0, 0, 32'h0000_8001, 32'h0,        32'h1122_3344, 0, 0, 0, 3, 1, 32'h1122_3344, 32'h0,        3'd0, 0, 0, 32'h0000_7002, 16'd6, 2'd3};
    vecs[8] = '{"err_rd", 0, 2, 32'h0000_A000, 32'h0,        32'hBADB_ADBA, 0, 1, 1, 4, 1, 32'h0,        32'h0,        3'd2, 0, 1, 32'h0000_A000, 16'd7, 2'd3};

    rst = 1'b0; dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'd0;
    dmem_addr = '0; dmem_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset htrans/hwrite/hsize/resp", {24'd0, htrans, hwrite, hsize, dmem_resp, bus_err}, 32'd0);
    chk("reset haddr|hwdata|rdata", haddr | hwdata | dmem_rdata | err_addr, 32'd0);
    chk("reset wait_cnt", {16'd0, wait_cnt}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back reads with dmem_req held through the response cycle.
    ns1 = -1; ns2 = -1; ns_n = 0; rsp_n = 0; rd2 = '0; lat_ok = 0;
    @(negedge clk);
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2;
    dmem_addr = 32'h0000_B000; hrdata = 32'h0BAD_F00D; hready = 1'b1; hresp = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (htrans == 2'b10) begin
        ns_n++;
        if (ns1 < 0) ns1 = cyc; else if (ns2 < 0) ns2 = cyc;
      end
      if (dmem_resp) begin
        rsp_n++;
        if (rsp_n == 1 && cyc == 3) lat_ok++;
        if (rsp_n == 2) begin
          rd2 = dmem_rdata; dmem_req = 1'b0;
          if (cyc == 7) lat_ok++;
        end
      end
    end
    chk("b2b first nonseq", ns1, 1);
    chk("b2b second nonseq", ns2, 5);
    chk("b2b nonseq count", ns_n, 2);
    chk("b2b resp count", rsp_n, 2);
    chk("b2b resp cycles", lat_ok, 2);
    chk("b2b rdata", rd2, 32'h0BAD_F00D);

    // Asynchronous reset while the data phase is stalled.
    @(negedge clk);
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2;
    dmem_addr = 32'h0000_C000; hrdata = 32'h7777_7777; hready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst-seq nonseq", {30'd0, htrans}, 32'd2);
    @(negedge clk);
    hready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst haddr", haddr, 32'd0);
    chk("async rst wait_cnt", {16'd0, wait_cnt}, 32'd0);
    chk("async rst err_addr", err_addr, 32'd0);
    chk("async rst misc", {22'd0, htrans, hwrite, hsize, dmem_resp, bus_err, misalign, 1'b0},
        32'd0);
    chk("async rst data", hwdata | dmem_rdata, 32'd0);
    dmem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; hready = 1'b1;
    rsp_n = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (dmem_resp || htrans != 2'b00) rsp_n++;
    end
    chk("no resp after reset", rsp_n, 0);
    run_vec('{"post_rst", 0, 2, 32'h0000_9000, 32'h0, 32'h5A5A_0001, 0, 1, 0, 4, 1,
              32'h5A5A_0001, 32'h0, 3'd2, 0, 0, 32'h0, 16'd1, 2'd1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
